ahb_subordinate_memory: RTL and testbench

//  AHB-Lite subordinate memory model at the downstream end of the AHB bus. It consumes the

---
 rtl/ahb_subordinate_memory.sv | 156 +++++++++++++++
 tb/tb_ahb_subordinate_memory.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_subordinate_memory.sv
// AHB-Lite subordinate memory: pipelined address/data-phase responder with
// configurable OKAY wait states and a two-cycle ERROR response.
module ahb_subordinate_memory #(
  parameter int                    ADDR_WIDTH    = 32,
  parameter int                    DATA_WIDTH    = 32,
  parameter int                    MEM_ADDR_BITS = 12,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR     = '0,
  parameter int                    WAIT_STATES   = 0
) (
  input  logic                    hclk,
  input  logic                    hreset,
  input  logic                    hselx,
  input  logic [ADDR_WIDTH-1:0]   haddr,
  input  logic [1:0]              htrans,
  input  logic                    hwrite,
  input  logic [2:0]              hsize,
  input  logic [2:0]              hburst,
  input  logic [DATA_WIDTH-1:0]   hwdata,
  input  logic [DATA_WIDTH/8-1:0] hwstrb,
  input  logic                    hready,
  output logic                    hreadyout,
  output logic                    hresp,
  output logic [DATA_WIDTH-1:0]   hrdata
);

  localparam int BPW       = DATA_WIDTH / 8;
  localparam int LANE_BITS = $clog2(BPW);
  localparam int WORD_BITS = MEM_ADDR_BITS - LANE_BITS;
  localparam int DEPTH     = 2 ** WORD_BITS;
  localparam logic [3:0] WCNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_DATA = 3'd2,
    S_ERR1 = 3'd3,
    S_ERR2 = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic [3:0]             wcnt_q, wcnt_d;
  logic [WORD_BITS-1:0]   widx_q, widx_d;
  logic [LANE_BITS-1:0]   lane_q, lane_d;
  logic [2:0]             size_q, size_d;
  logic                   write_q, write_d;

  logic [DATA_WIDTH-1:0]  mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0]  offset;
  logic [ADDR_WIDTH-1:0]  align_mask;
  logic                   accept;
  logic                   xfer_err;
  logic [BPW-1:0]         wr_lane;
  logic                   unused_inputs;

  // hburst is informational only
  assign unused_inputs = ^hburst;

  // Address-phase decode: acceptance and the three error conditions
  always_comb begin
    offset     = haddr - BASE_ADDR;
    align_mask = (ADDR_WIDTH'(1) << hsize) - ADDR_WIDTH'(1);
    accept     = hselx & hready & htrans[1];
    xfer_err   = (|offset[ADDR_WIDTH-1:MEM_ADDR_BITS]) |
                 (hsize > 3'(LANE_BITS)) |
                 (|(haddr & align_mask));
  end

  // Next-state logic and bus response outputs
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    widx_d    = widx_q;
    lane_d    = lane_q;
    size_d    = size_q;
    write_d   = write_q;
    hreadyout = 1'b1;
    hresp     = 1'b0;
    case (state_q)
      S_WAIT: begin
        hreadyout = 1'b0;
        if (wcnt_q == 4'd0) state_d = S_DATA;
        else                wcnt_d  = wcnt_q - 4'd1;
      end
      S_ERR1: begin
        hreadyout = 1'b0;
        hresp     = 1'b1;
        state_d   = S_ERR2;
      end
      S_IDLE, S_DATA, S_ERR2: begin
        hresp = (state_q == S_ERR2);
        if (accept) begin
          widx_d  = offset[MEM_ADDR_BITS-1:LANE_BITS];
          lane_d  = offset[LANE_BITS-1:0];
          size_d  = hsize;
          write_d = hwrite;
          if (xfer_err) begin
            state_d = S_ERR1;
          end else if (WAIT_STATES == 0) begin
            state_d = S_DATA;
          end else begin
            state_d = S_WAIT;
            wcnt_d  = WCNT_INIT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Byte lanes to commit: strobed and inside the size-aligned window
  always_comb begin
    wr_lane = '0;
    for (int i = 0; i < BPW; i++) begin
      if (hwstrb[i] && (i >= int'(lane_q)) && (i < int'(lane_q) + (1 << size_q)))
        wr_lane[i] = 1'b1;
    end
  end

  // Read data only while an OKAY data phase completes
  always_comb begin
    hrdata = '0;
    if (state_q == S_DATA) hrdata = mem_q[widx_q];
  end

  // Control state with synchronous reset
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q <= S_IDLE;
      wcnt_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Latched address-phase attributes
  always_ff @(posedge hclk) begin
    widx_q  <= widx_d;
    lane_q  <= lane_d;
    size_q  <= size_d;
    write_q <= write_d;
  end

  // Write commit on the completing OKAY edge; a reset on that edge drops it
  always_ff @(posedge hclk) begin
    if (!hreset && (state_q == S_DATA) && write_q) begin
      for (int i = 0; i < BPW; i++) begin
        if (wr_lane[i]) mem_q[widx_q][8*i +: 8] <= hwdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ahb_subordinate_memory.sv
// Scoreboard bench: two instances (0 and 3 wait states) share one bus;
// a reference byte model predicts every completion.
module tb_ahb_subordinate_memory;

  localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;
  localparam logic [2:0] SZ_B = 3'd0, SZ_H = 3'd1, SZ_W = 3'd2, SZ_D = 3'd3;

  typedef struct packed {
    logic [1:0]  trans;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } beat_t;

  typedef struct packed {
    logic        rd;
    logic        err;
    logic [7:0]  waits;
    logic [31:0] data;
  } exp_t;

  logic        hclk = 1'b0;
  logic        hreset;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  logic [3:0]  hwstrb;
  logic        tgt;
  logic        hsel0, hsel3;
  logic        hro0, hresp0, hro3, hresp3;
  logic [31:0] hrdata0, hrdata3;

  int n_checks = 0;
  int n_errors = 0;

  beat_t stim_q[$];
  string stag_q[$];
  exp_t  exp_q[$];
  string etag_q[$];
  logic [7:0] mdl [2][4096];

  assign hsel0 = hsel && (tgt == 1'b0);
  assign hsel3 = hsel && (tgt == 1'b1);

  always #5 hclk = ~hclk;

  ahb_subordinate_memory #(.WAIT_STATES(0)) dut0 (
    .hclk(hclk), .hreset(hreset), .hselx(hsel0), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata), .hwstrb(hwstrb),
    .hready(hro0), .hreadyout(hro0), .hresp(hresp0), .hrdata(hrdata0)
  );

  ahb_subordinate_memory #(.WAIT_STATES(3)) dut3 (
    .hclk(hclk), .hreset(hreset), .hselx(hsel3), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata), .hwstrb(hwstrb),
    .hready(hro3), .hreadyout(hro3), .hresp(hresp3), .hrdata(hrdata3)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic add(input logic [1:0] tr, input logic wr, input logic [2:0] sz,
                     input logic [31:0] a, input logic [31:0] wd, input logic [3:0] sb,
                     input string tag);
    beat_t b;
    b.trans = tr; b.wr = wr; b.size = sz; b.addr = a; b.wdata = wd; b.strb = sb;
    stim_q.push_back(b);
    stag_q.push_back(tag);
  endtask

  // Predict the response of one beat and update the reference memory
  task automatic push_expect(input beat_t b, input string tag);
    exp_t e;
    logic [31:0] off;
    int w, lo, span;
    e = '0;
    if (b.trans[1]) begin
      off   = b.addr;
      e.err = (off >= 32'd4096) || (b.size > SZ_W) ||
              ((b.addr & ((32'd1 << b.size) - 32'd1)) != 32'd0);
      e.waits = e.err ? 8'd1 : (tgt ? 8'd3 : 8'd0);
      if (!e.err) begin
        w    = int'(off & 32'hFFC);
        lo   = int'(off & 32'h3);
        span = 1 << b.size;
        if (b.wr) begin
          for (int i = 0; i < 4; i++)
            if (b.strb[i] && i >= lo && i < lo + span) mdl[tgt][w+i] = b.wdata[8*i +: 8];
        end else begin
          e.rd   = 1'b1;
          e.data = {mdl[tgt][w+3], mdl[tgt][w+2], mdl[tgt][w+1], mdl[tgt][w]};
        end
      end
    end
    exp_q.push_back(e);
    etag_q.push_back(tag);
  endtask

  task automatic load_next(output logic v, output beat_t b);
    string tag;
    if (stim_q.size() > 0) begin
      b = stim_q.pop_front();
      tag = stag_q.pop_front();
      hsel = 1'b1; htrans = b.trans; hwrite = b.wr; hsize = b.size; haddr = b.addr;
      push_expect(b, tag);
      v = 1'b1;
    end else begin
      b = '0;
      hsel = 1'b0; htrans = T_IDLE; hwrite = 1'b0;
      v = 1'b0;
    end
  endtask

  // Drive queued beats pipelined on the bus and score each completion
  task automatic run(input int budget);
    beat_t cur;
    logic  cur_v, dp_v, rdy, rsp, acc;
    logic [31:0] rd;
    int waits, bad_wresp, cyc;
    exp_t e;
    string t;
    dp_v = 1'b0; waits = 0; bad_wresp = 0; cyc = 0;
    @(posedge hclk); #1;
    load_next(cur_v, cur);
    while ((cur_v || dp_v) && cyc < budget) begin
      @(negedge hclk);
      cyc++;
      rdy = tgt ? hro3 : hro0;
      rsp = tgt ? hresp3 : hresp0;
      rd  = tgt ? hrdata3 : hrdata0;
      if (dp_v) begin
        if (!rdy) begin
          waits++;
          if (rsp !== exp_q[0].err) bad_wresp++;
        end else begin
          e = exp_q.pop_front();
          t = etag_q.pop_front();
          check_eq({t, "_resp"}, {31'd0, rsp}, {31'd0, e.err});
          check_eq({t, "_waits"}, waits, {24'd0, e.waits});
          if (e.waits > 0) check_eq({t, "_wresp"}, bad_wresp, 0);
          if (e.rd) check_eq({t, "_rdata"}, rd, e.data);
          dp_v = 1'b0;
        end
      end
      acc = rdy && cur_v;
      @(posedge hclk); #1;
      if (acc) begin
        dp_v = 1'b1; waits = 0; bad_wresp = 0;
        hwdata = cur.wdata; hwstrb = cur.strb;
        load_next(cur_v, cur);
      end
    end
    check_eq("run_pending", {31'd0, cur_v | dp_v}, 32'd0);
    check_eq("sb_left", exp_q.size(), 32'd0);
    exp_q.delete(); etag_q.delete();
  endtask

  initial begin
    hreset = 1'b1; hsel = 1'b0; haddr = '0; htrans = T_IDLE; hwrite = 1'b0;
    hsize = SZ_W; hburst = 3'b000; hwdata = '0; hwstrb = '0; tgt = 1'b0;
    repeat (3) @(posedge hclk);
    @(negedge hclk);
    check_eq("rst_hro0", {31'd0, hro0}, 32'd1);
    check_eq("rst_hresp0", {31'd0, hresp0}, 32'd0);
    check_eq("rst_hrdata0", hrdata0, 32'd0);
    check_eq("rst_hro3", {31'd0, hro3}, 32'd1);
    check_eq("rst_hresp3", {31'd0, hresp3}, 32'd0);
    check_eq("rst_hrdata3", hrdata3, 32'd0);
    @(posedge hclk); #1;
    hreset = 1'b0;

    // Zero-wait write then read of the same word
    tgt = 1'b0;
    add(T_NSEQ, 1'b1, SZ_W, 32'h10, 32'hDEADBEEF, 4'hF, "t1_wr");
    add(T_NSEQ, 1'b0, SZ_W, 32'h10, 32'h0, 4'h0, "t1_rd");
    run(200);

    // Three wait states on each OKAY
    tgt = 1'b1;
    add(T_NSEQ, 1'b1, SZ_W, 32'h80, 32'hCAFEF00D, 4'hF, "t2_wr");
    add(T_NSEQ, 1'b0, SZ_W, 32'h80, 32'h0, 4'h0, "t2_rd");
    run(200);

    // Out-of-range write must not touch the aliased word
    tgt = 1'b0;
    add(T_NSEQ, 1'b1, SZ_W, 32'h0, 32'h11223344, 4'hF, "t3_pre");
    add(T_NSEQ, 1'b1, SZ_W, 32'h1000, 32'hFFFFFFFF, 4'hF, "t3_oor");
    add(T_NSEQ, 1'b0, SZ_W, 32'h0, 32'h0, 4'h0, "t3_rd");
    run(200);

    // Misalignment, oversize and halfword lane window
    add(T_NSEQ, 1'b1, SZ_W, 32'h2, 32'h99999999, 4'hF, "t4_mis");
    add(T_NSEQ, 1'b1, SZ_H, 32'h2, 32'hABCD0000, 4'hC, "t4_half");
    add(T_NSEQ, 1'b1, SZ_D, 32'h8, 32'h77777777, 4'hF, "t4_big");
    add(T_NSEQ, 1'b0, SZ_W, 32'h0, 32'h0, 4'h0, "t4_rd");
    run(200);
    check_eq("t4_model", {mdl[0][3], mdl[0][2], mdl[0][1], mdl[0][0]}, 32'hABCD3344);

    // INCR4 burst with a BUSY slot, then readback
    hburst = 3'b011;
    add(T_NSEQ, 1'b1, SZ_W, 32'h20, 32'hA0A0A0A0, 4'hF, "t5_b0");
    add(T_BUSY, 1'b1, SZ_W, 32'h24, 32'h0, 4'h0, "t5_busy");
    add(T_SEQ, 1'b1, SZ_W, 32'h24, 32'hB1B2B3B4, 4'hF, "t5_b1");
    add(T_SEQ, 1'b1, SZ_W, 32'h28, 32'hC5C6C7C8, 4'hF, "t5_b2");
    add(T_SEQ, 1'b1, SZ_W, 32'h2C, 32'hD9DADBDC, 4'hF, "t5_b3");
    run(200);
    hburst = 3'b000;
    for (int i = 0; i < 4; i++)
      add(T_NSEQ, 1'b0, SZ_W, 32'h20 + 32'(4*i), 32'h0, 4'h0, "t5_rd");
    run(200);

    // Reset during the wait states of a write drops it
    tgt = 1'b1;
    add(T_NSEQ, 1'b1, SZ_W, 32'h40, 32'h55AA55AA, 4'hF, "t6_pre");
    run(200);
    @(posedge hclk); #1;
    hsel = 1'b1; htrans = T_NSEQ; hwrite = 1'b1; hsize = SZ_W; haddr = 32'h40;
    @(posedge hclk); #1;
    hwdata = 32'h12345678; hwstrb = 4'hF; hsel = 1'b0; htrans = T_IDLE;
    @(negedge hclk);
    check_eq("t6_inwait", {31'd0, hro3}, 32'd0);
    @(posedge hclk); #1;
    hreset = 1'b1;
    @(posedge hclk); #1;
    hreset = 1'b0;
    @(negedge hclk);
    check_eq("t6_hro", {31'd0, hro3}, 32'd1);
    check_eq("t6_hresp", {31'd0, hresp3}, 32'd0);
    add(T_NSEQ, 1'b0, SZ_W, 32'h40, 32'h0, 4'h0, "t6_rd");
    run(200);
    check_eq("t6_model", {mdl[1][67], mdl[1][66], mdl[1][65], mdl[1][64]}, 32'h55AA55AA);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
